instruction_sequencer: RTL
==========================

Name: instruction_sequencer

Overview:
Control stage directly upstream of alu_registers. It fetches 16-bit instructions from a synchronous program memory, decodes them, and drives alu_registers' addr_a/addr_b/addr_r/data_in/op for exactly one cycle per instruction. It has a program counter, jump support, halt, and a sticky illegal-opcode flag.

Parameters:
PC_WIDTH, 8, width of program counter and instruction-memory address
INSTR_WIDTH, 16, instruction width; the encoding below requires 16

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; starts execution from pc=0 (IDLE or HALTED only)
imem_addr  output  PC_WIDTH  program memory address, equal to pc
imem_data  input  INSTR_WIDTH  program memory read data, valid one cycle after imem_addr
addr_a  output  3  alu_registers operand A / write-target register
addr_b  output  3  alu_registers operand B register
addr_r  output  3  alu_registers result register
data_in  output  8  immediate for REG_WRITE
op  output  constants_pkg::ALUOp  operation to alu_registers
pc  output  PC_WIDTH  current program counter
halted  output  1  high while in HALTED
illegal  output  1  sticky: an undefined opcode was decoded since reset/start

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-instruction): state=IDLE, pc=0, ir=0, op=REG_READ, addr_a=addr_b=addr_r=0, data_in=0, halted=0, illegal=0. No register write may occur after reset is asserted.
- Encoding, opcode=ir[15:12]:
  - 0x0 NOP
  - 0x1 LOADI rd=ir[10:8], imm=ir[7:0] -> op=REG_WRITE, addr_a=rd, data_in=imm
  - 0x2 ADD rd=ir[10:8], ra=ir[6:4], rb=ir[2:0] -> op=ADD, addr_a=ra, addr_b=rb, addr_r=rd
  - 0x4 JMP target=ir[7:0]
  - 0xF HALT
  - all others are illegal: behave as NOP and set illegal=1
- Idle value of op is REG_READ. It is driven in every cycle except the EXEC cycle of LOADI/ADD.
- imem_addr is driven combinationally from the registered pc.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALTED.
  - IDLE: start -> FETCH, pc=0, illegal=0.
  - FETCH: memory samples imem_addr; unconditionally -> DECODE.
  - DECODE: ir<=imem_data. On the same edge, the ALU control outputs are registered from imem_data. -> EXEC.
  - EXEC: control outputs are valid for exactly this one cycle. At the end edge: op returns to REG_READ (addr/data_in hold last values).
    - pc<=target for JMP, otherwise pc<=pc+1 (mod 2^PC_WIDTH; 0xFF wraps to 0x00).
    - HALT -> HALTED with halted=1 and pc unchanged (points at the HALT). Otherwise -> FETCH.
  - HALTED: holds. start -> FETCH, pc=0, halted=0, illegal=0.
- start is ignored in FETCH, DECODE and EXEC.
- Throughput is 3 cycles per instruction. If start is sampled at edge E0, instruction i has its EXEC cycle between edges E0+3i+2 and E0+3i+3.
- No data forwarding is needed. alu_registers commits at the end of EXEC, before the next instruction's EXEC.

Test Plan:
- Reset: hold reset_n=0, then release. All outputs read 0, op=REG_READ, halted=0, illegal=0. Without start, pc stays 0 indefinitely.
- Basic sum, with alu_registers attached. Program: 0x1142 (LOADI r1,0x42), 0x1024 (LOADI r0,0x24), 0x2201 (ADD r2,r0,r1), 0xF000. Required: halted rises at E0+12, pc=3, r0=0x24, r1=0x42, r2=0x66. op is non-REG_READ in exactly 3 cycles.
- Fibonacci. Program: LOADI r0,0 / r1,1 / r2,1, then ADD r3=r1+r2, r4=r2+r3, r5=r3+r4, r6=r4+r5, r7=r5+r6, then HALT. Required: r0..r7 = 0x00,0x01,0x01,0x02,0x03,0x05,0x08,0x0d.
- Jump and wrap:
  - Program mem[0]=0x1001, mem[1]=0x4005, mem[2]=0x10FF, mem[5]=0xF000. Required: r0=0x01 (mem[2] never executes), halted with pc=0x05.
  - Second program mem[0]=0x40FF, mem[0xFF]=0x0000, mem[0x00] reached again. Required: the fetch after 0xFF uses imem_addr=0x00.
- Illegal opcode. Program 0x7123, then 0x1355, then 0xF000. Required: illegal=1 from the DECODE edge onward, op stays REG_READ for 0x7123, r3=0x55, halted=1. A subsequent start clears illegal.
- Reset and start edge cases:
  - Assert reset_n=0 during the EXEC cycle of LOADI r4,0xAA. Required: op=REG_READ immediately and r4 is unchanged.
  - Pulse start during DECODE of a running program. Required: no effect on pc or state.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute sequencer that drives alu_registers with one control
// beat per 16-bit instruction, with jump, halt and a sticky illegal-opcode flag.

package constants_pkg;
  typedef enum logic [2:0] {
    REG_READ  = 3'd0,
    REG_WRITE = 3'd1,
    ADD       = 3'd2,
    SUB       = 3'd3,
    AND_OP    = 3'd4,
    OR_OP     = 3'd5,
    XOR_OP    = 3'd6,
    PASS_A    = 3'd7
  } ALUOp;
endpackage

module instruction_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [2:0]             addr_a,
  output logic [2:0]             addr_b,
  output logic [2:0]             addr_r,
  output logic [7:0]             data_in,
  output constants_pkg::ALUOp    op,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output logic                   illegal
);
  import constants_pkg::*;

  localparam logic [3:0] OPC_NOP   = 4'h0;
  localparam logic [3:0] OPC_LOADI = 4'h1;
  localparam logic [3:0] OPC_ADD   = 4'h2;
  localparam logic [3:0] OPC_JMP   = 4'h4;
  localparam logic [3:0] OPC_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  typedef struct packed {
    ALUOp       op;
    logic [2:0] addr_a;
    logic [2:0] addr_b;
    logic [2:0] addr_r;
    logic [7:0] data_in;
  } ctrl_t;

  function automatic logic opcode_legal(input logic [3:0] opc);
    logic ok;
    case (opc)
      OPC_NOP, OPC_LOADI, OPC_ADD, OPC_JMP, OPC_HALT: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Fields not touched by an instruction keep their previous value.
  function automatic ctrl_t decode_ctrl(input logic [3:0] opc, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb,
                                        input logic [7:0] imm, input ctrl_t prev);
    ctrl_t c;
    c    = prev;
    c.op = REG_READ;
    case (opc)
      OPC_LOADI: begin
        c.op      = REG_WRITE;
        c.addr_a  = rd;
        c.data_in = imm;
      end
      OPC_ADD: begin
        c.op     = ADD;
        c.addr_a = ra;
        c.addr_b = rb;
        c.addr_r = rd;
      end
      default: c.op = REG_READ;
    endcase
    return c;
  endfunction

  state_t                   state_r;
  state_t                   state_next_s;
  logic [PC_WIDTH-1:0]      pc_r;
  logic [PC_WIDTH-1:0]      pc_next_s;
  logic [INSTR_WIDTH-1:0]   ir_r;
  logic [INSTR_WIDTH-1:0]   ir_next_s;
  ctrl_t                    ctrl_r;
  ctrl_t                    ctrl_next_s;
  logic                     halted_r;
  logic                     halted_next_s;
  logic                     illegal_r;
  logic                     illegal_next_s;
  logic [3:0]               exec_opc_s;
  logic                     unused_bits_s;

  assign exec_opc_s    = ir_r[15:12];
  assign unused_bits_s = ^{imem_data[11], ir_r[11:8]};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: fixed three-cycle FETCH/DECODE/EXEC loop.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) state_next_s = ST_FETCH;
        else       state_next_s = state_r;
      end
      ST_FETCH:  state_next_s = ST_DECODE;
      ST_DECODE: state_next_s = ST_EXEC;
      ST_EXEC: begin
        if (exec_opc_s == OPC_HALT) state_next_s = ST_HALTED;
        else                        state_next_s = ST_FETCH;
      end
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Next values for pc, ir, control beat and status flags.
  always_comb begin
    pc_next_s      = pc_r;
    ir_next_s      = ir_r;
    ctrl_next_s    = ctrl_r;
    halted_next_s  = halted_r;
    illegal_next_s = illegal_r;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_next_s      = '0;
          halted_next_s  = 1'b0;
          illegal_next_s = 1'b0;
        end else begin
          pc_next_s      = pc_r;
        end
      end
      ST_FETCH: ctrl_next_s.op = REG_READ;
      ST_DECODE: begin
        // Control beat is registered straight from memory so it lands in EXEC.
        ir_next_s      = imem_data;
        ctrl_next_s    = decode_ctrl(imem_data[15:12], imem_data[10:8], imem_data[6:4],
                                     imem_data[2:0], imem_data[7:0], ctrl_r);
        illegal_next_s = illegal_r | ~opcode_legal(imem_data[15:12]);
      end
      ST_EXEC: begin
        ctrl_next_s.op = REG_READ;
        if (exec_opc_s == OPC_JMP) begin
          pc_next_s = PC_WIDTH'(ir_r[7:0]);
        end else if (exec_opc_s == OPC_HALT) begin
          pc_next_s     = pc_r;
          halted_next_s = 1'b1;
        end else begin
          pc_next_s = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: pc_next_s = pc_r;
    endcase
  end

  // Datapath and output registers; reset forces op to REG_READ immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r      <= '0;
      ir_r      <= '0;
      ctrl_r    <= '0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      pc_r      <= pc_next_s;
      ir_r      <= ir_next_s;
      ctrl_r    <= ctrl_next_s;
      halted_r  <= halted_next_s;
      illegal_r <= illegal_next_s;
    end
  end

  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign op        = ctrl_r.op;
  assign addr_a    = ctrl_r.addr_a;
  assign addr_b    = ctrl_r.addr_b;
  assign addr_r    = ctrl_r.addr_r;
  assign data_in   = ctrl_r.data_in;
  assign halted    = halted_r;
  assign illegal   = illegal_r;

endmodule
